// File: rtl/shreg_pkg.sv
// rtl/shreg_pkg.sv - shared types and helpers for the universal shift register
//
// Purpose: operating-mode encoding and counter sizing used by
//          shift_reg_universal and shreg_frame_counter.
// Ports:   none (package).

package shreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shreg_mode_t;

  // Bit width of the per-frame shift counter (counts 0..width-1).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shreg_frame_counter.sv
// rtl/shreg_frame_counter.sv - counts shifts within a WIDTH-bit serial frame
//
// Purpose: tracks how many shifts have accumulated in the current frame and
//          flags the shift that completes it.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   clr     in   synchronous restart of the frame (highest priority)
//   load    in   parallel load: restarts the frame
//   shift   in   one shift (either direction) happens on this edge
//   bit_cnt out  shifts accumulated in the current frame
//   wrap    out  combinational: this edge's shift completes the frame

module shreg_frame_counter
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         load,
  input  logic                         shift,
  output logic [cnt_width(WIDTH)-1:0]  bit_cnt,
  output logic                         wrap
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Wrap is decoded explicitly so non-power-of-two widths restart at WIDTH.
  assign wrap = shift && (bit_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (clr || load) begin
      bit_cnt <= '0;
    end else if (shift) begin
      bit_cnt <= wrap ? '0 : bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_reg_universal.sv
// rtl/shift_reg_universal.sv - parametrised universal shift register with framing
//
// Purpose: hold / shift-right / shift-left / parallel-load register that also
//          counts serial shifts and snapshots each completed WIDTH-bit word.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   en           in   operation enable; low forces hold
//   clr          in   synchronous clear, highest synchronous priority
//   mode         in   00 hold, 01 shift right, 10 shift left, 11 load
//   ser_in_msb   in   bit entering q[WIDTH-1] on shift right
//   ser_in_lsb   in   bit entering q[0] on shift left
//   pin          in   parallel load data
//   pout         out  live register contents
//   ser_out_msb  out  q[WIDTH-1]
//   ser_out_lsb  out  q[0]
//   bit_cnt      out  shifts accumulated in the current frame
//   word_valid   out  one-cycle pulse after a frame completes
//   frame_word   out  q snapshot taken at frame completion

module shift_reg_universal
  import shreg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         clr,
  input  logic [1:0]                   mode,
  input  logic                         ser_in_msb,
  input  logic                         ser_in_lsb,
  input  logic [WIDTH-1:0]             pin,
  output logic [WIDTH-1:0]             pout,
  output logic                         ser_out_msb,
  output logic                         ser_out_lsb,
  output logic [cnt_width(WIDTH)-1:0]  bit_cnt,
  output logic                         word_valid,
  output logic [WIDTH-1:0]             frame_word
);

  shreg_mode_t      mode_e;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             do_shift;
  logic             do_load;
  logic             wrap;

  assign mode_e   = shreg_mode_t'(mode);
  assign do_shift = !clr && en && ((mode_e == MODE_SHR) || (mode_e == MODE_SHL));
  assign do_load  = !clr && en && (mode_e == MODE_LOAD);

  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = RESET_VAL;
    end else if (en) begin
      unique case (mode_e)
        MODE_SHR:  q_next = {ser_in_msb, q[WIDTH-1:1]};
        MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in_lsb};
        MODE_LOAD: q_next = pin;
        default:   q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else begin
      q <= q_next;
    end
  end

  shreg_frame_counter #(
    .WIDTH (WIDTH)
  ) u_frame_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .load    (do_load),
    .shift   (do_shift),
    .bit_cnt (bit_cnt),
    .wrap    (wrap)
  );

  // The snapshot takes the post-shift value so frame_word equals pout
  // during the word_valid cycle; clr leaves the last snapshot in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_valid <= 1'b0;
      frame_word <= '0;
    end else begin
      word_valid <= wrap;
      if (wrap) begin
        frame_word <= q_next;
      end
    end
  end

  assign pout        = q;
  assign ser_out_msb = q[WIDTH-1];
  assign ser_out_lsb = q[0];

endmodule

// File: tb/tb_shift_reg_universal.sv
// tb/tb_shift_reg_universal.sv - self-checking bench for shift_reg_universal

module tb_shift_reg_universal;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic [1:0]   mode;
  logic         ser_in_msb;
  logic         ser_in_lsb;
  logic [W-1:0] pin;
  logic [W-1:0] pout;
  logic         ser_out_msb;
  logic         ser_out_lsb;
  logic [1:0]   bit_cnt;
  logic         word_valid;
  logic [W-1:0] frame_word;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_reg_universal #(
    .WIDTH     (W),
    .RESET_VAL ('0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clr         (clr),
    .mode        (mode),
    .ser_in_msb  (ser_in_msb),
    .ser_in_lsb  (ser_in_lsb),
    .pin         (pin),
    .pout        (pout),
    .ser_out_msb (ser_out_msb),
    .ser_out_lsb (ser_out_lsb),
    .bit_cnt     (bit_cnt),
    .word_valid  (word_valid),
    .frame_word  (frame_word)
  );

  typedef struct {
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic       msb;
    logic       lsb;
    logic [3:0] pin;
    logic [3:0] q;
    logic [1:0] cnt;
    logic       wv;
    logic [3:0] fw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, input logic c, input logic [1:0] m,
                              input logic smsb, input logic slsb, input logic [3:0] p,
                              input logic [3:0] eq, input logic [1:0] ecnt,
                              input logic ewv, input logic [3:0] efw);
    vec_t v;
    v.en = e; v.clr = c; v.mode = m; v.msb = smsb; v.lsb = slsb; v.pin = p;
    v.q = eq; v.cnt = ecnt; v.wv = ewv; v.fw = efw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eq, input logic [1:0] ecnt,
                           input logic ewv, input logic [3:0] efw);
    chk({tag, ".pout"},        {4'b0, pout},        {4'b0, eq});
    chk({tag, ".bit_cnt"},     {6'b0, bit_cnt},     {6'b0, ecnt});
    chk({tag, ".word_valid"},  {7'b0, word_valid},  {7'b0, ewv});
    chk({tag, ".frame_word"},  {4'b0, frame_word},  {4'b0, efw});
    chk({tag, ".ser_out_msb"}, {7'b0, ser_out_msb}, {7'b0, eq[3]});
    chk({tag, ".ser_out_lsb"}, {7'b0, ser_out_lsb}, {7'b0, eq[0]});
  endtask

  task automatic drive(input logic e, input logic c, input logic [1:0] m,
                       input logic smsb, input logic slsb, input logic [3:0] p);
    en = e; clr = c; mode = m; ser_in_msb = smsb; ser_in_lsb = slsb; pin = p;
    @(posedge clk);
    #1;
  endtask

  // Reference model: shifts counted since the last restart; every fourth
  // shift completes a frame.
  int mq, mn, mfw, mwv;

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'b00;
    ser_in_msb = 1'b0; ser_in_lsb = 1'b0; pin = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 4'h0, 2'd0, 1'b0, 4'h0);
    rst_n = 1'b1;

    //            en clr mode msb lsb pin    q    cnt wv fw
    // SIPO left
    tbl.push_back(mk(1, 0, 2'b10, 0, 1, 4'h0, 4'h1, 1, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 0, 4'h0, 4'h2, 2, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 1, 4'h0, 4'h5, 3, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 1, 4'h0, 4'hB, 0, 1, 4'hB));
    tbl.push_back(mk(1, 0, 2'b00, 0, 0, 4'h0, 4'hB, 0, 0, 4'hB));
    // clr beats load; frame_word kept
    tbl.push_back(mk(1, 1, 2'b11, 0, 0, 4'hF, 4'h0, 0, 0, 4'hB));
    // SIPO right, two back-to-back frames
    tbl.push_back(mk(1, 0, 2'b01, 1, 0, 4'h0, 4'h8, 1, 0, 4'hB));
    tbl.push_back(mk(1, 0, 2'b01, 0, 0, 4'h0, 4'h4, 2, 0, 4'hB));
    tbl.push_back(mk(1, 0, 2'b01, 1, 0, 4'h0, 4'hA, 3, 0, 4'hB));
    tbl.push_back(mk(1, 0, 2'b01, 1, 0, 4'h0, 4'hD, 0, 1, 4'hD));
    tbl.push_back(mk(1, 0, 2'b01, 0, 0, 4'h0, 4'h6, 1, 0, 4'hD));
    tbl.push_back(mk(1, 0, 2'b01, 0, 0, 4'h0, 4'h3, 2, 0, 4'hD));
    tbl.push_back(mk(1, 0, 2'b01, 0, 0, 4'h0, 4'h1, 3, 0, 4'hD));
    tbl.push_back(mk(1, 0, 2'b01, 0, 0, 4'h0, 4'h0, 0, 1, 4'h0));
    // PISO: load 0101, shift left out of msb
    tbl.push_back(mk(1, 0, 2'b11, 0, 0, 4'h5, 4'h5, 0, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 0, 4'h0, 4'hA, 1, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 0, 4'h0, 4'h4, 2, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 0, 4'h0, 4'h8, 3, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 0, 4'h0, 4'h0, 0, 1, 4'h0));
    // Hold / enable
    tbl.push_back(mk(1, 0, 2'b11, 0, 0, 4'hA, 4'hA, 0, 0, 4'h0));
    tbl.push_back(mk(0, 0, 2'b01, 1, 1, 4'h3, 4'hA, 0, 0, 4'h0));
    tbl.push_back(mk(0, 0, 2'b10, 1, 1, 4'h3, 4'hA, 0, 0, 4'h0));
    tbl.push_back(mk(0, 0, 2'b11, 1, 1, 4'h3, 4'hA, 0, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b00, 1, 1, 4'h3, 4'hA, 0, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b00, 1, 1, 4'h3, 4'hA, 0, 0, 4'h0));
    // Priority: clr over load, then load restarts the frame
    tbl.push_back(mk(1, 1, 2'b11, 0, 0, 4'hF, 4'h0, 0, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 1, 4'h0, 4'h1, 1, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 1, 4'h0, 4'h3, 2, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 1, 4'h0, 4'h7, 3, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b11, 0, 0, 4'h9, 4'h9, 0, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 0, 4'h0, 4'h2, 1, 0, 4'h0));
    // Mixed directions within one frame
    tbl.push_back(mk(1, 0, 2'b01, 1, 0, 4'h0, 4'h9, 2, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 1, 4'h0, 4'h3, 3, 0, 4'h0));
    tbl.push_back(mk(1, 0, 2'b01, 0, 0, 4'h0, 4'h1, 0, 1, 4'h1));
    tbl.push_back(mk(1, 1, 2'b01, 1, 1, 4'h0, 4'h0, 0, 0, 4'h1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].mode, tbl[i].msb, tbl[i].lsb, tbl[i].pin);
      check_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].cnt, tbl[i].wv, tbl[i].fw);
    end

    // Asynchronous reset mid-frame
    drive(1, 0, 2'b10, 0, 1, 4'h0);
    drive(1, 0, 2'b10, 0, 1, 4'h0);
    check_all("pre_rst", 4'h3, 2'd2, 1'b0, 4'h1);
    mode = 2'b00;
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 4'h0, 2'd0, 1'b0, 4'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 2'b10, 0, 1, 4'h0);
    check_all("post_rst1", 4'h1, 2'd1, 1'b0, 4'h0);
    drive(1, 0, 2'b10, 0, 1, 4'h0);
    check_all("post_rst2", 4'h3, 2'd2, 1'b0, 4'h0);
    drive(1, 0, 2'b10, 0, 1, 4'h0);
    check_all("post_rst3", 4'h7, 2'd3, 1'b0, 4'h0);
    drive(1, 0, 2'b10, 0, 1, 4'h0);
    check_all("post_rst4", 4'hF, 2'd0, 1'b1, 4'hF);

    // Randomised run against the reference model
    mq = 15; mn = 0; mfw = 15; mwv = 0;
    for (int i = 0; i < 400; i++) begin
      logic       e, c, smsb, slsb;
      logic [1:0] m;
      logic [3:0] p;
      e    = ($urandom_range(0, 9) != 0);
      c    = ($urandom_range(0, 19) == 0);
      m    = 2'($urandom_range(0, 3));
      smsb = 1'($urandom_range(0, 1));
      slsb = 1'($urandom_range(0, 1));
      p    = 4'($urandom_range(0, 15));
      drive(e, c, m, smsb, slsb, p);
      mwv = 0;
      if (c) begin
        mq = 0; mn = 0;
      end else if (e && m == 2'b11) begin
        mq = p; mn = 0;
      end else if (e && (m == 2'b01 || m == 2'b10)) begin
        if (m == 2'b01) mq = smsb * 8 + mq / 2;
        else            mq = (mq * 2 + slsb) % 16;
        mn = mn + 1;
        if (mn % 4 == 0) begin
          mwv = 1;
          mfw = mq;
        end
      end
      check_all($sformatf("rnd%0d", i), 4'(mq), 2'(mn % 4), 1'(mwv), 4'(mfw));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
Parametrised universal shift register that generalises the fixed 4-bit SIPO/PIPO registers.
- Operating modes: hold, shift-right, shift-left and parallel load, selected at run time.
- A frame counter flags each completed WIDTH-bit serial word and snapshots it.
- Sits between serial links and parallel datapaths; one instance serves as SIPO, PISO, SISO or PIPO.

Parameters:
WIDTH, 8, register width in bits; legal range 2..64.
RESET_VAL, '0, value loaded into q on reset and on clr.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  operation enable; 0 forces hold regardless of mode
clr  input  1  synchronous clear, highest synchronous priority
mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load
ser_in_msb  input  1  bit entering q[WIDTH-1] on shift right
ser_in_lsb  input  1  bit entering q[0] on shift left
pin  input  WIDTH  parallel load data
pout  output  WIDTH  live register contents q
ser_out_msb  output  1  q[WIDTH-1], combinational from q
ser_out_lsb  output  1  q[0], combinational from q
bit_cnt  output  clog2(WIDTH)  shifts accumulated in the current frame
word_valid  output  1  one-cycle pulse when a frame completes
frame_word  output  WIDTH  q snapshot taken at frame completion

Behaviour:
Reset (rst_n low, asynchronous, any time):
- q=RESET_VAL, bit_cnt=0, word_valid=0, frame_word=0.
- An in-progress frame is discarded; after release, a full WIDTH shifts are needed again.

Per-edge priority: clr > !en > mode.
- clr=1: q=RESET_VAL, bit_cnt=0, word_valid=0; frame_word keeps its value.
- en=0: q and bit_cnt hold; word_valid=0.
- mode 00: hold, same effect as en=0.
- mode 01: q <= {ser_in_msb, q[WIDTH-1:1]}.
- mode 10: q <= {q[WIDTH-2:0], ser_in_lsb}.
- mode 11: q <= pin, bit_cnt <= 0, word_valid=0.

Frame counter (shift modes only):
- Each shift increments bit_cnt.
- On the shift where bit_cnt==WIDTH-1:
  - bit_cnt wraps to 0.
  - word_valid=1 in the following cycle.
  - frame_word captures the post-shift q value, i.e. the same value as pout in that cycle.
- word_valid is registered, lasts exactly one cycle and is 0 on every other edge.
- Back-to-back frames give a word_valid pulse every WIDTH enabled shifts with no bubble.
- Mixing left and right shifts within a frame is legal; the counter counts both.

Latency and outputs:
- Latency from input to pout is 1 clock.
- ser_out_* follow q with no added delay.
- PISO usage: ser_out_msb with shift left, or ser_out_lsb with shift right.

Decomposition:
Package shreg_pkg:
- typedef enum logic [1:0] shreg_mode_t with members MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD.
- Function cnt_width(WIDTH) returning $clog2(WIDTH).

Sub-module shreg_frame_counter:
- Inputs: clk, rst_n, clr, load, shift.
- Outputs: bit_cnt, wrap pulse.
- The top level owns q and frame_word.

Test Plan:
All scenarios use WIDTH=4, RESET_VAL=0 and en=1 unless stated.
1. SIPO left: mode=10, ser_in_lsb=1,0,1,1 on 4 edges -> q=0001,0010,0101,1011; word_valid=1 for 1 cycle after the 4th edge; frame_word=1011; bit_cnt=1,2,3,0.
2. SIPO right: mode=01, ser_in_msb=1,0,1,1 -> q=1000,0100,1010,1101; frame_word=1101; a further 4 shifts give a second pulse exactly 4 cycles later.
3. PISO: mode=11 with pin=0101, then mode=10 with ser_in_lsb=0 for 4 edges -> ser_out_msb=0,1,0,1,0; bit_cnt=0 after load; pulse after the 4th shift; q=0000.
4. Hold/enable: load 1010, then en=0 for 3 edges, then mode=00 for 2 edges -> q stays 1010, bit_cnt stays 0, no pulse.
5. Reset mid-frame: shift left 2 bits (q=0011), assert rst_n low between edges -> q, bit_cnt and frame_word are 0 immediately; after release, 4 shifts are needed for word_valid.
6. Priority: clr=1 with mode=11 and pin=1111 -> q=0000, bit_cnt=0; then 3 shifts, load, 1 shift -> no word_valid (counter restarted by the load).
